// File: rtl/free_reg_list.sv
// free_reg_list: circular free list of physical register indices for rename.
// Hands up to two free registers per cycle to the RAT and accepts up to two
// released registers per cycle from commit. Outputs read registered state only.
module free_reg_list #(
    parameter int unsigned NUM_PHYS_REGS = 64,
    parameter int unsigned NUM_ARCH_REGS = 32,
    localparam int unsigned DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS,
    localparam int unsigned PW    = $clog2(NUM_PHYS_REGS),
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           taken,
    output logic [1:0][PW-1:0]   free_register,
    output logic [1:0]           free_valid,
    output logic                 all_reg_full_stall,
    input  logic [1:0]           free_en,
    input  logic [1:0][PW-1:0]   free_idx,
    output logic [CW-1:0]        free_count,
    output logic                 proto_err
);

    localparam logic [AW:0] DepthPtr = (AW + 1)'(DEPTH);
    localparam logic [CW:0] DepthCnt = (CW + 1)'(DEPTH);

    // Advance a pointer by 0..2 entries, wrapping modulo DEPTH.
    function automatic logic [AW-1:0] ptr_add(input logic [AW-1:0] p, input logic [1:0] n);
        logic [AW:0] s;
        s = {1'b0, p} + {{(AW - 1){1'b0}}, n};
        if (s >= DepthPtr) begin
            s = s - DepthPtr;
        end
        return s[AW-1:0];
    endfunction

    logic [PW-1:0] r_entries [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_proto_err;

    logic [AW-1:0] w_head_p1;
    logic [AW-1:0] w_tail_p1;
    logic [1:0]    w_valid;
    logic          w_take_illegal;
    logic          w_take_under;
    logic          w_take_err;
    logic [1:0]    w_n_take;
    logic [1:0]    w_n_free_req;
    logic [CW:0]   w_count_sum;
    logic          w_overflow;
    logic          w_do_free;
    logic [1:0]    w_n_free;
    logic [CW:0]   w_count_next;

    // Read side: lanes come straight from the array at head and head+1.
    always_comb begin
        w_head_p1          = ptr_add(r_head, 2'd1);
        w_tail_p1          = ptr_add(r_tail, 2'd1);
        w_valid            = {(r_count >= CW'(2)), (r_count >= CW'(1))};
        free_register[0]   = r_entries[r_head];
        free_register[1]   = r_entries[w_head_p1];
        free_valid         = w_valid;
        all_reg_full_stall = (r_count < CW'(2));
        free_count         = r_count;
        proto_err          = r_proto_err;
    end

    // Decode take/free requests and reject illegal, underflowing or overflowing ones.
    always_comb begin
        w_take_illegal = (taken == 2'b10);
        w_take_under   = (taken[0] && !w_valid[0]) || (taken[1] && !w_valid[1]);
        w_take_err     = w_take_illegal || w_take_under;

        w_n_take = 2'd0;
        if (!w_take_err) begin
            case (taken)
                2'b01:   w_n_take = 2'd1;
                2'b11:   w_n_take = 2'd2;
                default: w_n_take = 2'd0;
            endcase
        end

        w_n_free_req = {free_en[1] & free_en[0], free_en[1] ^ free_en[0]};

        // Take is bounded by count, so this difference never goes negative.
        w_count_sum = {1'b0, r_count} - {{(CW - 1){1'b0}}, w_n_take}
                      + {{(CW - 1){1'b0}}, w_n_free_req};
        w_overflow  = (w_count_sum > DepthCnt);

        // An overflowing free request is dropped whole; the take still proceeds.
        w_do_free    = (free_en != 2'b00) && !w_overflow;
        w_n_free     = w_do_free ? w_n_free_req : 2'd0;
        w_count_next = {1'b0, r_count} - {{(CW - 1){1'b0}}, w_n_take}
                       + {{(CW - 1){1'b0}}, w_n_free};
    end

    // Entry storage: reset seeds the unmapped physical registers, commit writes at tail.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= PW'(NUM_ARCH_REGS + i);
            end
        end else if (w_do_free) begin
            case (free_en)
                2'b11: begin
                    r_entries[r_tail]    <= free_idx[0];
                    r_entries[w_tail_p1] <= free_idx[1];
                end
                2'b01:   r_entries[r_tail] <= free_idx[0];
                2'b10:   r_entries[r_tail] <= free_idx[1];
                default: ;
            endcase
        end
    end

    // Pointers, occupancy and the registered protocol-error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= CW'(DEPTH);
            r_proto_err <= 1'b0;
        end else begin
            r_head      <= ptr_add(r_head, w_n_take);
            r_tail      <= ptr_add(r_tail, w_n_free);
            r_count     <= w_count_next[CW-1:0];
            r_proto_err <= w_take_err || ((free_en != 2'b00) && w_overflow);
        end
    end

endmodule

// File: doc/free_reg_list.md
# free_reg_list

Circular free list of physical register indices for the rename stage. Supplies up to two free physical registers per cycle to the RAT (`free_register`, consumed via `taken`) and accepts up to two released registers per cycle from commit. Drives the RAT's `all_reg_full_stall` when fewer than two free registers are available. Sits between the RAT (consumer) and the ROB commit path (producer); indices address the same physical register file as the RAT.

## Interface
- `NUM_PHYS_REGS`, 64, physical registers in the register file (from `reg_pkg`)
- `NUM_ARCH_REGS`, 32, architectural registers; physical regs 0..NUM_ARCH_REGS-1 are mapped at reset
- `DEPTH`, NUM_PHYS_REGS-NUM_ARCH_REGS, list capacity (derived, do not override)
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `taken`  in  2  RAT consumed lane i's register this cycle; legal values 00, 01, 11
- `free_register`  out  2 x clog2(NUM_PHYS_REGS)  lane 0 = head entry, lane 1 = head+1 entry
- `free_valid`  out  2  lane i entry is valid (count > i)
- `all_reg_full_stall`  out  1  count < 2
- `free_en`  in  2  commit releases `free_idx[i]`
- `free_idx`  in  2 x clog2(NUM_PHYS_REGS)  released physical register indices
- `free_count`  out  clog2(DEPTH)+1  current entry count
- `proto_err`  out  1  one-cycle pulse on illegal take or overflow

## Operation
- Storage: DEPTH-entry array, `head` and `tail` pointers of clog2(DEPTH) bits, wrapping modulo DEPTH; `count` disambiguates full/empty.
- Reset (async, `rst`=0): entry[i] = NUM_ARCH_REGS+i, head=0, tail=0, count=DEPTH; outputs therefore `free_register`={33,32} (lane1,lane0), `free_valid`=11, `all_reg_full_stall`=0, `free_count`=32, `proto_err`=0.
- Dequeue: n_take = 0 for 00, 1 for 01, 2 for 11; head += n_take.
- Illegal take: `taken`=10 -> nothing dequeued, `proto_err` pulses next cycle. `taken[i]` with `free_valid[i]`=0 (underflow) -> nothing dequeued, `proto_err` pulses.
- Enqueue: free_en=11 writes idx[0] at tail, idx[1] at tail+1; free_en=01 or 10 writes the single asserted index at tail; tail += n_free.
- Overflow: if count - n_take + n_free > DEPTH, the whole free request is dropped (tail unchanged), `proto_err` pulses; legal dequeue still proceeds.
- count_next = count - n_take + n_free, computed in clog2(DEPTH)+2 bits, never wraps.
- No bypass: registers released in cycle N become visible on `free_register` no earlier than N+1, and only when they reach head.

## Timing
- `free_register`, `free_valid`, `all_reg_full_stall`, `free_count` are combinational reads of registered state (head, count, array); no input-to-output combinational path.
- Take/free in cycle N take effect at the rising edge ending N; new head entries visible in N+1.
- Simultaneous take and free in the same cycle are both applied; with count=1, taken=01 and free_en=11 -> count=2 next cycle, head = the first released index.
- Simultaneous take and free at count=DEPTH: take 2 + free 2 is legal (count stays DEPTH).
- Reset asserted mid-operation: state returns to reset values immediately (async); first take honoured on the first rising edge after `rst` deasserts.
- `proto_err` is registered: high exactly one cycle after the offending cycle.

## Test plan
- Reset: after `rst` release -> `free_register[0]`=32, `[1]`=33, `free_valid`=11, `free_count`=32, stall=0.
- Drain: taken=11 for 15 cycles -> `free_count`=2, heads {62,63}; one more taken=11 -> count=0, `free_valid`=00, stall=1.
- Wrap: from empty, free_en=11 idx {5,7} then {9,11} -> count=4, heads 5,7; taken=11 -> heads 9,11, tail/head wrapped past entry 31 correctly.
- Simultaneous: count=1 (head=63), taken=01 with free_en=11 idx {4,6} -> next cycle count=2, heads 4,6.
- Errors: taken=10 at reset -> count stays 32, `proto_err`=1 one cycle later; at count=32, free_en=01 with taken=00 -> dropped, `proto_err` pulses, count=32.
- Async reset: after 3 cycles of taken=11, drop `rst` mid-cycle -> outputs return to reset values before next edge.
